// File: rtl/riscy_arb_pkg.sv
// rtl/riscy_arb_pkg.sv - shared types and constants for the RI5CY memory arbiter
package riscy_arb_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } arb_state_e;

    localparam logic [3:0] INSTR_BE = 4'hF;

endpackage

// File: rtl/riscy_mem_arbiter_if.sv
// rtl/riscy_mem_arbiter_if.sv - fetch, LSU and memory req/gnt/rvalid bundle for the arbiter
interface riscy_mem_arbiter_if #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int AW              = 32
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic          instr_req_i;
    logic [AW-1:0] instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;

    logic          data_req_i;
    logic          data_we_i;
    logic [3:0]    data_be_i;
    logic [AW-1:0] data_addr_i;
    logic [31:0]   data_wdata_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [31:0]   data_rdata_o;

    logic          mem_req_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [31:0]   mem_rdata_i;

    logic [CW-1:0] out_cnt_o;
    logic          resp_err_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output out_cnt_o, resp_err_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  out_cnt_o, resp_err_o
    );

endinterface

// File: rtl/riscy_owner_fifo.sv
// rtl/riscy_owner_fifo.sv - in-order 1-bit FIFO recording which port owns each granted transaction
module riscy_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          din_i,
    input  logic          pop_i,
    output logic          head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop_ok) begin
                rd_q <= ptr_inc(rd_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/riscy_mem_arbiter.sv
// rtl/riscy_mem_arbiter.sv - round-robin sharing of one memory port between RI5CY fetch and LSU
module riscy_mem_arbiter
    import riscy_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int AW              = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    riscy_mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e    state_q, state_d;
    owner_e        last_q, last_d, sel;
    logic          req, mem_req, grant, pop;
    logic          resp_err_q;
    logic          fifo_full, fifo_empty, fifo_head;
    logic [CW-1:0] fifo_cnt;
    logic [AW-1:0] addr_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB;
            last_q     <= OWN_DATA;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            resp_err_q <= resp_err_q | (bus.mem_rvalid_i & fifo_empty);
        end
    end

    // A held winner stays on mem_* until granted so address/data never change mid-request.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel     = OWN_INSTR;
        req     = 1'b0;
        case (state_q)
            ARB: begin
                if (!fifo_full && (bus.instr_req_i || bus.data_req_i)) begin
                    if (bus.instr_req_i && bus.data_req_i) begin
                        sel = (last_q == OWN_DATA) ? OWN_INSTR : OWN_DATA;
                    end else begin
                        sel = bus.instr_req_i ? OWN_INSTR : OWN_DATA;
                    end
                    req = 1'b1;
                    if (bus.mem_gnt_i) begin
                        last_d = sel;
                    end else begin
                        state_d = (sel == OWN_INSTR) ? HOLD_I : HOLD_D;
                    end
                end
            end
            HOLD_I: begin
                sel = OWN_INSTR;
                req = bus.instr_req_i;
                if (!bus.instr_req_i || bus.mem_gnt_i) state_d = ARB;
                if (bus.instr_req_i && bus.mem_gnt_i)  last_d  = OWN_INSTR;
            end
            HOLD_D: begin
                sel = OWN_DATA;
                req = bus.data_req_i;
                if (!bus.data_req_i || bus.mem_gnt_i) state_d = ARB;
                if (bus.data_req_i && bus.mem_gnt_i)  last_d  = OWN_DATA;
            end
            default: state_d = ARB;
        endcase
    end

    assign mem_req  = req & rst_ni;
    assign grant    = mem_req & bus.mem_gnt_i;
    assign pop      = bus.mem_rvalid_i & ~fifo_empty & rst_ni;
    assign addr_sel = (sel == OWN_INSTR) ? bus.instr_addr_i : bus.data_addr_i;

    riscy_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CW    (CW)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .din_i   (sel),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_addr_o  = addr_sel;
    assign bus.mem_we_o    = (sel == OWN_DATA) & bus.data_we_i;
    assign bus.mem_be_o    = (sel == OWN_INSTR) ? INSTR_BE : bus.data_be_i;
    assign bus.mem_wdata_o = (sel == OWN_INSTR) ? 32'h0 : bus.data_wdata_i;

    assign bus.instr_gnt_o    = grant & (sel == OWN_INSTR);
    assign bus.data_gnt_o     = grant & (sel == OWN_DATA);
    assign bus.instr_rvalid_o = pop & (fifo_head == OWN_INSTR);
    assign bus.data_rvalid_o  = pop & (fifo_head == OWN_DATA);
    assign bus.instr_rdata_o  = rst_ni ? bus.mem_rdata_i : 32'h0;
    assign bus.data_rdata_o   = rst_ni ? bus.mem_rdata_i : 32'h0;

    assign bus.out_cnt_o  = fifo_cnt;
    assign bus.resp_err_o = resp_err_q;

endmodule

// File: tb/tb_riscy_mem_arbiter.sv
// tb/tb_riscy_mem_arbiter.sv - directed and randomized self-checking bench for riscy_mem_arbiter
module tb_riscy_mem_arbiter;
    import riscy_arb_pkg::*;

    localparam int MAXO = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    riscy_mem_arbiter_if #(.MAX_OUTSTANDING(MAXO), .AW(32)) bus ();

    riscy_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .AW(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_i(input logic req, input logic [31:0] addr);
        bus.instr_req_i  = req;
        bus.instr_addr_i = addr;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_req_i   = req;
        bus.data_we_i    = we;
        bus.data_be_i    = be;
        bus.data_addr_i  = addr;
        bus.data_wdata_i = wdata;
    endtask

    task automatic set_m(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        bus.mem_gnt_i    = gnt;
        bus.mem_rvalid_i = rvalid;
        bus.mem_rdata_i  = rdata;
    endtask

    task automatic idle();
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1'b0, 1'b0, 32'h0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int       q[$];
        int       last_m, held, w, head;
        logic     ri, rd, wed, g, rv;
        logic [31:0] ai, ad, wd, rdat;
        logic [3:0]  bed;

        // reset: everything forced quiet even with live inputs
        set_i(1'b1, 32'h80);
        set_d(1'b1, 1'b1, 4'hF, 32'h3E, 32'h5);
        set_m(1'b1, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        chk("rst_mem_req", bus.mem_req_o, 0);
        chk("rst_instr_gnt", bus.instr_gnt_o, 0);
        chk("rst_data_gnt", bus.data_gnt_o, 0);
        chk("rst_instr_rvalid", bus.instr_rvalid_o, 0);
        chk("rst_data_rvalid", bus.data_rvalid_o, 0);
        chk("rst_instr_rdata", bus.instr_rdata_o, 0);
        chk("rst_data_rdata", bus.data_rdata_o, 0);
        chk("rst_out_cnt", 32'(bus.out_cnt_o), 0);
        chk("rst_resp_err", bus.resp_err_o, 0);
        idle();
        rst_n = 1'b1;
        nxt();

        // single fetch, response two cycles later
        set_i(1'b1, 32'h80);
        set_m(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t1_instr_gnt", bus.instr_gnt_o, 1);
        chk("t1_data_gnt", bus.data_gnt_o, 0);
        chk("t1_mem_req", bus.mem_req_o, 1);
        chk("t1_mem_addr", bus.mem_addr_o, 32'h80);
        chk("t1_mem_be", 32'(bus.mem_be_o), 32'hF);
        chk("t1_mem_we", bus.mem_we_o, 0);
        chk("t1_mem_wdata", bus.mem_wdata_o, 0);
        nxt();
        idle();
        @(negedge clk);
        chk("t1_cnt1", 32'(bus.out_cnt_o), 1);
        nxt();
        set_m(1'b0, 1'b1, 32'h000FA103);
        @(negedge clk);
        chk("t1_instr_rvalid", bus.instr_rvalid_o, 1);
        chk("t1_data_rvalid", bus.data_rvalid_o, 0);
        chk("t1_instr_rdata", bus.instr_rdata_o, 32'h000FA103);
        nxt();
        idle();
        @(negedge clk);
        chk("t1_cnt0", 32'(bus.out_cnt_o), 0);
        nxt();

        // fresh reset so the first tie goes to instr; then alternate I,D,I,D,I
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_i(1'b1, 32'h100);
        set_d(1'b1, 1'b1, 4'hF, 32'h3E, 32'h5);
        for (int k = 0; k < 5; k++) begin
            set_m(1'b1, k > 0, 32'(k));
            @(negedge clk);
            chk($sformatf("t2_instr_gnt_%0d", k), bus.instr_gnt_o, (k % 2) == 0);
            chk($sformatf("t2_data_gnt_%0d", k), bus.data_gnt_o, (k % 2) == 1);
            if (k > 0) begin
                chk($sformatf("t2_instr_rvalid_%0d", k), bus.instr_rvalid_o, (k % 2) == 1);
                chk($sformatf("t2_data_rvalid_%0d", k), bus.data_rvalid_o, (k % 2) == 0);
            end
            if ((k % 2) == 1) begin
                chk("t2_mem_we", bus.mem_we_o, 1);
                chk("t2_mem_addr", bus.mem_addr_o, 32'h3E);
                chk("t2_mem_wdata", bus.mem_wdata_o, 32'h5);
                chk("t2_mem_be", 32'(bus.mem_be_o), 32'hF);
            end
            nxt();
        end
        idle();
        set_m(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("t2_last_instr_rvalid", bus.instr_rvalid_o, 1);
        nxt();
        idle();
        @(negedge clk);
        chk("t2_cnt0", 32'(bus.out_cnt_o), 0);
        nxt();

        // data wins the tie (last was instr) and is locked through 3 stalled cycles
        set_i(1'b1, 32'h200);
        set_d(1'b1, 1'b0, 4'h3, 32'h10, 32'hAB);
        set_m(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3_mem_req_%0d", k), bus.mem_req_o, 1);
            chk($sformatf("t3_mem_addr_%0d", k), bus.mem_addr_o, 32'h10);
            chk($sformatf("t3_instr_gnt_%0d", k), bus.instr_gnt_o, 0);
            chk($sformatf("t3_data_gnt_%0d", k), bus.data_gnt_o, 0);
            if (k > 0) chk($sformatf("t3_state_%0d", k), 32'(dut.state_q), 32'(HOLD_D));
            nxt();
        end
        set_m(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t3_data_gnt", bus.data_gnt_o, 1);
        chk("t3_instr_gnt_held", bus.instr_gnt_o, 0);
        chk("t3_mem_be", 32'(bus.mem_be_o), 32'h3);
        chk("t3_state_hold", 32'(dut.state_q), 32'(HOLD_D));
        nxt();
        set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t3_instr_gnt_after", bus.instr_gnt_o, 1);
        chk("t3_instr_addr", bus.mem_addr_o, 32'h200);
        nxt();
        idle();
        set_m(1'b0, 1'b1, 32'h11);
        @(negedge clk);
        chk("t3_data_rvalid", bus.data_rvalid_o, 1);
        chk("t3_data_rdata", bus.data_rdata_o, 32'h11);
        nxt();
        set_m(1'b0, 1'b1, 32'h22);
        @(negedge clk);
        chk("t3_instr_rvalid", bus.instr_rvalid_o, 1);
        nxt();
        idle();
        nxt();

        // FIFO full: third request blocked, even in the cycle of a pop
        set_i(1'b1, 32'h300);
        set_m(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t4_instr_gnt", bus.instr_gnt_o, 1);
        nxt();
        set_i(1'b0, 32'h0);
        set_d(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        @(negedge clk);
        chk("t4_data_gnt", bus.data_gnt_o, 1);
        nxt();
        set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_i(1'b1, 32'h304);
        @(negedge clk);
        chk("t4_cnt_full", 32'(bus.out_cnt_o), 2);
        chk("t4_mem_req_full", bus.mem_req_o, 0);
        chk("t4_instr_gnt_full", bus.instr_gnt_o, 0);
        nxt();
        set_m(1'b1, 1'b1, 32'h33);
        @(negedge clk);
        chk("t4_mem_req_pop", bus.mem_req_o, 0);
        chk("t4_instr_rvalid", bus.instr_rvalid_o, 1);
        chk("t4_data_rvalid_none", bus.data_rvalid_o, 0);
        nxt();
        set_m(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t4_cnt_after_pop", 32'(bus.out_cnt_o), 1);
        chk("t4_mem_req_resume", bus.mem_req_o, 1);
        chk("t4_instr_gnt_resume", bus.instr_gnt_o, 1);
        chk("t4_addr_resume", bus.mem_addr_o, 32'h304);
        nxt();
        idle();
        set_m(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("t4_data_rvalid", bus.data_rvalid_o, 1);
        nxt();
        set_m(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("t4_instr_rvalid2", bus.instr_rvalid_o, 1);
        nxt();
        idle();
        @(negedge clk);
        chk("t4_cnt0", 32'(bus.out_cnt_o), 0);
        nxt();

        // stray response with nothing outstanding
        set_m(1'b0, 1'b1, 32'h55);
        @(negedge clk);
        chk("t5_instr_rvalid", bus.instr_rvalid_o, 0);
        chk("t5_data_rvalid", bus.data_rvalid_o, 0);
        nxt();
        idle();
        @(negedge clk);
        chk("t5_resp_err", bus.resp_err_o, 1);
        chk("t5_cnt", 32'(bus.out_cnt_o), 0);
        nxt();
        @(negedge clk);
        chk("t5_resp_err_sticky", bus.resp_err_o, 1);
        nxt();
        set_i(1'b1, 32'h400);
        set_m(1'b1, 1'b0, 32'h0);
        nxt();
        set_i(1'b0, 32'h0);
        set_d(1'b1, 1'b0, 4'hF, 32'h44, 32'h0);
        nxt();
        idle();
        chk("t5_cnt2", 32'(bus.out_cnt_o), 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cnt", 32'(bus.out_cnt_o), 0);
        chk("t5_rst_err", bus.resp_err_o, 0);
        chk("t5_rst_mem_req", bus.mem_req_o, 0);
        #1;
        rst_n = 1'b1;
        nxt();

        // randomized traffic against a queue model of owners
        q.delete();
        last_m = 1;
        held   = -1;
        ri = 1'b0; rd = 1'b0; wed = 1'b0;
        ai = 0; ad = 0; wd = 0; bed = 0;
        for (int c = 0; c < 400; c++) begin
            if (!ri && $urandom_range(0, 2) != 0) begin
                ri = 1'b1;
                ai = $urandom;
            end
            if (!rd && $urandom_range(0, 2) != 0) begin
                rd  = 1'b1;
                ad  = $urandom;
                wed = 1'($urandom_range(0, 1));
                bed = 4'($urandom);
                wd  = $urandom;
            end
            g    = $urandom_range(0, 3) != 0;
            rv   = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            rdat = $urandom;
            set_i(ri, ai);
            set_d(rd, wed, bed, ad, wd);
            set_m(g, rv, rdat);

            w = -1;
            if (held >= 0) w = held;
            else if (q.size() < MAXO) begin
                if (ri && rd) w = (last_m == 1) ? 0 : 1;
                else if (ri)  w = 0;
                else if (rd)  w = 1;
            end
            head = (q.size() > 0) ? q[0] : -1;

            @(negedge clk);
            chk("rnd_mem_req", bus.mem_req_o, w >= 0);
            chk("rnd_instr_gnt", bus.instr_gnt_o, (w == 0) && g);
            chk("rnd_data_gnt", bus.data_gnt_o, (w == 1) && g);
            chk("rnd_instr_rvalid", bus.instr_rvalid_o, rv && (head == 0));
            chk("rnd_data_rvalid", bus.data_rvalid_o, rv && (head == 1));
            chk("rnd_rdata", bus.data_rdata_o, rdat);
            if (w == 0) begin
                chk("rnd_i_addr", bus.mem_addr_o, ai);
                chk("rnd_i_we", bus.mem_we_o, 0);
                chk("rnd_i_be", 32'(bus.mem_be_o), 32'hF);
            end
            if (w == 1) begin
                chk("rnd_d_addr", bus.mem_addr_o, ad);
                chk("rnd_d_we", bus.mem_we_o, wed);
                chk("rnd_d_be", 32'(bus.mem_be_o), 32'(bed));
                chk("rnd_d_wdata", bus.mem_wdata_o, wd);
            end

            if (rv) void'(q.pop_front());
            if (w >= 0 && g) begin
                q.push_back(w);
                last_m = w;
                held   = -1;
                if (w == 0) ri = 1'b0;
                else        rd = 1'b0;
            end else if (w >= 0) begin
                held = w;
            end
            nxt();
            chk("rnd_out_cnt", 32'(bus.out_cnt_o), 32'(q.size()));
            chk("rnd_resp_err", bus.resp_err_o, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
